// File: rtl/core_mem_ctrl_pkg.sv
// core_mem_ctrl_pkg: shared state encodings, constants and request helpers for the core memory controller.
package core_mem_ctrl_pkg;

    localparam logic [1:0] CMC_IDLE   = 2'd0;
    localparam logic [1:0] CMC_BUS_IF = 2'd1;
    localparam logic [1:0] CMC_BUS_D  = 2'd2;
    localparam logic [1:0] CMC_RESP   = 2'd3;

    localparam logic [31:0] CMC_NOP      = 32'h0000_0013;
    localparam logic [31:0] CMC_DEADBEEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [1:0] off;
        logic       is_byte;
        logic       is_half;
        logic       is_uns;
    } cmc_req_t;

    function automatic logic cmc_misaligned(input logic [1:0] off, input logic is_byte, input logic is_half);
        return is_byte ? 1'b0 : is_half ? (off == 2'b11) : (off != 2'b00);
    endfunction

endpackage

// File: rtl/core_mem_ctrl_if.sv
// core_mem_ctrl_if: fetch/data requester and memory bus signals of the core memory controller.
// master = the controller, slave = requesters plus the memory bus slave.
interface core_mem_ctrl_if;

    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_DONE;
    logic [31:0] IF_RDATA;
    logic        IF_ERR;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [3:0]  D_STRB;
    logic [31:0] D_WDATA;
    logic        D_ISLOADBS;
    logic        D_ISLOADHWS;
    logic        D_UNSIGNED;
    logic        D_DONE;
    logic [31:0] D_RDATA;
    logic        D_ERR;
    logic        M_VALID;
    logic        M_WE;
    logic [31:0] M_ADDR;
    logic [3:0]  M_STRB;
    logic [31:0] M_WDATA;
    logic        M_READY;
    logic [31:0] M_RDATA;
    logic        BUSY;

    modport master (
        input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_STRB, D_WDATA,
               D_ISLOADBS, D_ISLOADHWS, D_UNSIGNED, M_READY, M_RDATA,
        output IF_DONE, IF_RDATA, IF_ERR, D_DONE, D_RDATA, D_ERR,
               M_VALID, M_WE, M_ADDR, M_STRB, M_WDATA, BUSY
    );

    modport slave (
        output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_STRB, D_WDATA,
               D_ISLOADBS, D_ISLOADHWS, D_UNSIGNED, M_READY, M_RDATA,
        input  IF_DONE, IF_RDATA, IF_ERR, D_DONE, D_RDATA, D_ERR,
               M_VALID, M_WE, M_ADDR, M_STRB, M_WDATA, BUSY
    );

endinterface

// File: rtl/core_load_ext.sv
// core_load_ext: extracts a byte/halfword/word from a bus word and sign- or zero-extends it.
module core_load_ext (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic        i_byte,
    input  logic        i_half,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh   = i_rdata >> {i_offset, 3'b000};
    assign o_data = i_byte ? {{24{~i_unsigned & w_sh[7]}}, w_sh[7:0]} :
                    i_half ? {{16{~i_unsigned & w_sh[15]}}, w_sh[15:0]} : w_sh;

endmodule

// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: sequences the shared memory port between instruction fetch and data access,
// one transaction at a time, with alignment checks and an optional bus-wait timeout.
module core_mem_ctrl
    import core_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] NOP_INSTR      = CMC_NOP
) (
    input  logic CLK,
    input  logic NRST,
    core_mem_ctrl_if.master bus
);

    logic [1:0]  r_state;
    cmc_req_t    r_req;
    logic [31:0] r_cnt;
    logic        r_m_valid;
    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [3:0]  r_m_strb;
    logic [31:0] r_m_wdata;
    logic        r_if_done;
    logic        r_d_done;
    logic        r_if_err;
    logic        r_d_err;
    logic [31:0] r_d_rdata;
    logic [31:0] r_if_rdata;
    logic [31:0] w_ext;
    logic        w_to;
    logic        w_d_mis;

    core_load_ext u_load_ext (
        .i_rdata   (bus.M_RDATA),
        .i_offset  (r_req.off),
        .i_byte    (r_req.is_byte),
        .i_half    (r_req.is_half),
        .i_unsigned(r_req.is_uns),
        .o_data    (w_ext)
    );

    assign w_to    = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_d_mis = cmc_misaligned(bus.D_ADDR[1:0], bus.D_ISLOADBS, bus.D_ISLOADHWS);

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_state    <= CMC_IDLE;
            r_req      <= '0;
            r_cnt      <= '0;
            r_m_valid  <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_strb   <= '0;
            r_m_wdata  <= '0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_if_err   <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
            r_if_rdata <= NOP_INSTR;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_if_err  <= 1'b0;
            r_d_err   <= 1'b0;
            case (r_state)
                CMC_IDLE: begin
                    if (bus.D_REQ) begin
                        r_req <= '{off: bus.D_ADDR[1:0], is_byte: bus.D_ISLOADBS,
                                   is_half: bus.D_ISLOADHWS, is_uns: bus.D_UNSIGNED};
                        if (w_d_mis) begin
                            r_state  <= CMC_RESP;
                            r_d_done <= 1'b1;
                            r_d_err  <= 1'b1;
                        end else begin
                            r_state   <= CMC_BUS_D;
                            r_m_valid <= 1'b1;
                            r_m_we    <= bus.D_WE;
                            r_m_addr  <= {bus.D_ADDR[31:2], 2'b00};
                            r_m_strb  <= bus.D_STRB;
                            r_m_wdata <= bus.D_WDATA << {bus.D_ADDR[1:0], 3'b000};
                            r_cnt     <= '0;
                        end
                    end else if (bus.IF_REQ) begin
                        r_req <= '0;
                        if (bus.IF_ADDR[1:0] != 2'b00) begin
                            r_state    <= CMC_RESP;
                            r_if_done  <= 1'b1;
                            r_if_err   <= 1'b1;
                            r_if_rdata <= NOP_INSTR;
                        end else begin
                            r_state   <= CMC_BUS_IF;
                            r_m_valid <= 1'b1;
                            r_m_we    <= 1'b0;
                            r_m_addr  <= {bus.IF_ADDR[31:2], 2'b00};
                            r_m_strb  <= 4'b1111;
                            r_m_wdata <= '0;
                            r_cnt     <= '0;
                        end
                    end
                end
                CMC_BUS_IF, CMC_BUS_D: begin
                    if (bus.M_READY || w_to) begin
                        r_m_valid <= 1'b0;
                        r_state   <= CMC_RESP;
                        if (r_state == CMC_BUS_D) begin
                            r_d_done <= 1'b1;
                            r_d_err  <= ~bus.M_READY;
                            // stores leave the last load result in place
                            if (!bus.M_READY)
                                r_d_rdata <= CMC_DEADBEEF;
                            else if (!r_m_we)
                                r_d_rdata <= w_ext;
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_err   <= ~bus.M_READY;
                            r_if_rdata <= bus.M_READY ? bus.M_RDATA : NOP_INSTR;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= CMC_IDLE;
            endcase
        end
    end

    assign bus.M_VALID  = r_m_valid;
    assign bus.M_WE     = r_m_we;
    assign bus.M_ADDR   = r_m_addr;
    assign bus.M_STRB   = r_m_strb;
    assign bus.M_WDATA  = r_m_wdata;
    assign bus.IF_DONE  = r_if_done;
    assign bus.IF_ERR   = r_if_err;
    assign bus.IF_RDATA = r_if_rdata;
    assign bus.D_DONE   = r_d_done;
    assign bus.D_ERR    = r_d_err;
    assign bus.D_RDATA  = r_d_rdata;
    assign bus.BUSY     = (r_state != CMC_IDLE);

endmodule

// File: tb/tb_core_mem_ctrl.sv
// tb_core_mem_ctrl: table-driven, hand-sequenced and randomized checks of core_mem_ctrl
// against a behavioural model of the access rules, with a 4-cycle bus timeout.
module tb_core_mem_ctrl;

    localparam int TMO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] DBF = 32'hDEAD_BEEF;

    typedef struct {
        logic        is_d, we, isb, ish, uns;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  strb;
        int          delay;
        logic [31:0] e_maddr, e_wdata, e_rdata;
        logic [3:0]  e_strb;
        logic        mis, err;
    } txn_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_d_last = '0;
    txn_t tbl[14];

    core_mem_ctrl_if bus ();

    core_mem_ctrl #(.TIMEOUT_CYCLES(TMO), .NOP_INSTR(NOP)) dut (
        .CLK (clk),
        .NRST(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic is_d, we, isb, ish, uns, input logic [31:0] addr,
                                input logic [3:0] strb, input logic [31:0] wdata, rdata, input int delay,
                                input logic [31:0] e_maddr, input logic [3:0] e_strb,
                                input logic [31:0] e_wdata, e_rdata, input logic mis, err);
        txn_t t;
        t.is_d = is_d; t.we = we; t.isb = isb; t.ish = ish; t.uns = uns;
        t.addr = addr; t.strb = strb; t.wdata = wdata; t.rdata = rdata; t.delay = delay;
        t.e_maddr = e_maddr; t.e_strb = e_strb; t.e_wdata = e_wdata; t.e_rdata = e_rdata;
        t.mis = mis; t.err = err;
        return t;
    endfunction

    // Reference model: expected bus fields and results from plain arithmetic on the access rules.
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        longint off, v;
        off = longint'(t.addr % 4);
        r.mis = t.is_d ? (t.isb ? 1'b0 : t.ish ? (off == 3) : (off != 0)) : (off != 0);
        r.err = r.mis || (t.delay >= TMO);
        r.e_maddr = t.addr - 32'(off);
        r.e_strb = t.is_d ? t.strb : 4'hF;
        r.e_wdata = 32'(longint'(t.wdata) * (longint'(1) << (8 * off)));
        v = longint'(t.rdata) / (longint'(1) << (8 * off));
        if (t.isb) begin
            v = v % 256;
            if (!t.uns && v >= 128) v = v - 256;
        end else if (t.ish) begin
            v = v % 65536;
            if (!t.uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(t.rdata);
        end
        r.e_rdata = !t.is_d ? (r.err ? NOP : t.rdata) : (r.err ? DBF : 32'(v));
        return r;
    endfunction

    // Entered and left just after a falling edge with the controller idle.
    task automatic run_txn(input txn_t t, input string nm);
        int n = 0;
        bus.D_REQ = t.is_d; bus.IF_REQ = !t.is_d;
        bus.D_WE = t.we; bus.D_ADDR = t.addr; bus.IF_ADDR = t.addr;
        bus.D_STRB = t.strb; bus.D_WDATA = t.wdata;
        bus.D_ISLOADBS = t.isb; bus.D_ISLOADHWS = t.ish; bus.D_UNSIGNED = t.uns;
        bus.M_READY = 1'b0;
        @(negedge clk);
        while (bus.M_VALID && n < 12) begin
            chk({nm, "_maddr"}, bus.M_ADDR, t.e_maddr);
            chk({nm, "_mstrb"}, 32'(bus.M_STRB), 32'(t.e_strb));
            chk({nm, "_mwe"}, 32'(bus.M_WE), 32'(t.is_d & t.we));
            if (t.is_d) chk({nm, "_mwdata"}, bus.M_WDATA, t.e_wdata);
            chk({nm, "_early_done"}, 32'(bus.D_DONE | bus.IF_DONE), 32'd0);
            bus.M_READY = (n == t.delay);
            bus.M_RDATA = (n == t.delay) ? t.rdata : $urandom;
            n++;
            @(negedge clk);
        end
        bus.M_READY = 1'b0;
        chk({nm, "_vcycles"}, 32'(n), t.mis ? 32'd0 : (t.delay >= TMO ? 32'(TMO) : 32'(t.delay + 1)));
        chk({nm, "_d_done"}, 32'(bus.D_DONE), 32'(t.is_d));
        chk({nm, "_if_done"}, 32'(bus.IF_DONE), 32'(!t.is_d));
        if (t.is_d) begin
            chk({nm, "_d_err"}, 32'(bus.D_ERR), 32'(t.err));
            if (!t.mis && (t.err || !t.we)) begin
                chk({nm, "_d_rdata"}, bus.D_RDATA, t.e_rdata);
                exp_d_last = t.e_rdata;
            end else if (!t.mis) begin
                chk({nm, "_d_rdata_kept"}, bus.D_RDATA, exp_d_last);
            end
        end else begin
            chk({nm, "_if_err"}, 32'(bus.IF_ERR), 32'(t.err));
            chk({nm, "_if_rdata"}, bus.IF_RDATA, t.e_rdata);
        end
        bus.D_REQ = 1'b0; bus.IF_REQ = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, {bus.BUSY, bus.D_DONE, bus.IF_DONE, bus.M_VALID}, 32'd0);
    endtask

    initial begin
        bus.IF_REQ = 0; bus.IF_ADDR = 0; bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = 0;
        bus.D_STRB = 0; bus.D_WDATA = 0; bus.D_ISLOADBS = 0; bus.D_ISLOADHWS = 0;
        bus.D_UNSIGNED = 0; bus.M_READY = 0; bus.M_RDATA = 0;
        //            d  we b  h  u  addr         strb  wdata         rdata         dly maddr   strb  wdata         rdata         mis err
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h100, 4'hF, 32'h0,        32'h80FF7F01, 0, 32'h100, 4'hF, 32'h0,        32'h80FF7F01, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 32'h103, 4'h8, 32'h0,        32'h80FF7F01, 0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 1, 32'h103, 4'h8, 32'h0,        32'h80FF7F01, 1, 32'h100, 4'h8, 32'h0,        32'h00000080, 0, 0);
        tbl[3]  = mk(1, 1, 0, 1, 0, 32'h101, 4'h6, 32'h0000BEEF, 32'h0,        0, 32'h100, 4'h6, 32'h00BEEF00, 32'h0,        0, 0);
        tbl[4]  = mk(1, 0, 0, 1, 0, 32'h102, 4'hC, 32'h0,        32'h80FF7F01, 2, 32'h100, 4'hC, 32'h0,        32'hFFFF80FF, 0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 1, 32'h101, 4'h6, 32'h0,        32'h80FF7F01, 1, 32'h100, 4'h6, 32'h0,        32'h0000FF7F, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 32'h102, 4'hF, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1);
        tbl[7]  = mk(1, 0, 0, 1, 0, 32'h103, 4'h8, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 32'h200, 4'h0, 32'h0,        32'h00500093, 3, 32'h200, 4'hF, 32'h0,        32'h00500093, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 32'h202, 4'h0, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        NOP,          1, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 32'h104, 4'hF, 32'h0,        32'h0,        5, 32'h104, 4'hF, 32'h0,        DBF,          0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 32'h300, 4'h0, 32'h0,        32'h0,        9, 32'h300, 4'hF, 32'h0,        NOP,          0, 1);
        tbl[12] = mk(1, 1, 0, 0, 0, 32'h108, 4'hF, 32'h12345678, 32'h0,        0, 32'h108, 4'hF, 32'h12345678, 32'h0,        0, 0);
        tbl[13] = mk(1, 1, 1, 0, 0, 32'h10B, 4'h8, 32'h000000A5, 32'h0,        0, 32'h108, 4'h8, 32'hA5000000, 32'h0,        0, 0);

        repeat (2) @(negedge clk);
        chk("rst_outs", {bus.M_VALID, bus.M_WE, bus.IF_DONE, bus.D_DONE, bus.D_ERR, bus.IF_ERR, bus.BUSY}, 32'd0);
        chk("rst_bus", bus.M_ADDR | bus.M_WDATA | 32'(bus.M_STRB), 32'd0);
        chk("rst_d_rdata", bus.D_RDATA, 32'd0);
        chk("rst_if_rdata", bus.IF_RDATA, NOP);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Data wins over fetch; fetch follows in the IDLE after D_DONE.
        bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 32'h100; bus.D_STRB = 4'hF;
        bus.D_ISLOADBS = 0; bus.D_ISLOADHWS = 0; bus.D_UNSIGNED = 0;
        bus.IF_REQ = 1; bus.IF_ADDR = 32'h200; bus.M_READY = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("prio_valid%0d", k), 32'(bus.M_VALID), 32'd1);
            chk($sformatf("prio_maddr%0d", k), bus.M_ADDR, 32'h100);
            chk($sformatf("prio_mwe%0d", k), 32'(bus.M_WE), 32'd0);
            bus.M_READY = (k == 3);
            bus.M_RDATA = 32'h11223344;
            @(negedge clk);
        end
        bus.M_READY = 0;
        chk("prio_d_done", {bus.D_DONE, bus.IF_DONE, bus.M_VALID}, 32'b100);
        chk("prio_d_rdata", bus.D_RDATA, 32'h11223344);
        exp_d_last = 32'h11223344;
        bus.D_REQ = 0;
        @(negedge clk);
        chk("prio_idle_gap", {bus.BUSY, bus.M_VALID}, 32'd0);
        @(negedge clk);
        chk("prio_if_valid", 32'(bus.M_VALID), 32'd1);
        chk("prio_if_maddr", bus.M_ADDR, 32'h200);
        chk("prio_if_strb", 32'(bus.M_STRB), 32'hF);
        bus.M_READY = 1; bus.M_RDATA = 32'h00100073;
        @(negedge clk);
        bus.M_READY = 0;
        chk("prio_if_done", {bus.IF_DONE, bus.IF_ERR, bus.D_DONE}, 32'b100);
        chk("prio_if_rdata", bus.IF_RDATA, 32'h00100073);
        bus.IF_REQ = 0;
        @(negedge clk);

        // Reset while waiting in BUS_D.
        bus.D_REQ = 1; bus.D_ADDR = 32'h140;
        @(negedge clk);
        chk("rstmid_valid", {bus.M_VALID, bus.BUSY}, 32'b11);
        nrst = 1'b0;
        @(negedge clk);
        chk("rstmid_outs", {bus.M_VALID, bus.BUSY, bus.D_DONE, bus.IF_DONE}, 32'd0);
        chk("rstmid_if_rdata", bus.IF_RDATA, NOP);
        chk("rstmid_d_rdata", bus.D_RDATA, 32'd0);
        exp_d_last = '0;
        bus.D_REQ = 0; nrst = 1'b1;
        @(negedge clk);
        chk("rstmid_after", {bus.BUSY, bus.D_DONE, bus.M_VALID}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            txn_t t;
            int sel = $urandom_range(0, 2);
            t = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, sel == 1, sel == 2,
                   $urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom, $urandom,
                   $urandom_range(0, 5), 0, 0, 0, 0, 0, 0);
            run_txn(model(t), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
